// File: rtl/instr_trace_buffer.sv
// ---------------------------------------------------------------------------
// instr_trace_buffer
//
// Purpose:
//   Captures a window of issued GPU instructions into a small circular trace
//   buffer. The capture starts when an instruction at a programmed PC
//   (trig_pc) issues after an arm pulse. It ends on a stop pulse or, when
//   WRAP=0, when the buffer fills. Every entry holds the issuing warp index,
//   a coarse instruction class, the PC and the instruction word. The oldest
//   entry is presented on a valid/ready read port.
//
// Parameters:
//   NUM_WARPS  width of the one-hot warp vector (default 8)
//   DEPTH      number of trace entries, power of two, >= 4 (default 16)
//   WRAP       1: overwrite the oldest entry when full
//              0: freeze capture when full (default 1)
//
// Optional feature:
//   TRACE_WARP_FILTER_EN  adds input warp_mask. In CAPTURE, an issue from a
//                         masked-off warp is ignored: it is neither written
//                         nor counted as a drop.
//
// Ports:
//   clk, rst              clock; asynchronous active-high reset
//   in_valid              an instruction issued this cycle
//   in_warp_oh            one-hot issuing warp
//   in_instr, in_pc       instruction word and its PC
//   arm, stop             single-cycle control pulses
//   trig_pc               capture start PC, sampled when arm is high
//   warp_mask             (TRACE_WARP_FILTER_EN only) per-warp capture enable
//   rd_ready              consumer accepts the head entry
//   rd_valid, rd_warp, rd_class, rd_pc, rd_instr
//                         head entry; the fields read zero while empty
//   state                 0=IDLE 1=ARMED 2=CAPTURE 3=FROZEN
//   count                 number of stored entries
//   drop_cnt              saturating count of lost issues
// ---------------------------------------------------------------------------
module instr_trace_buffer #(
    parameter int NUM_WARPS = 8,
    parameter int DEPTH     = 16,
    parameter int WRAP      = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [NUM_WARPS-1:0]         in_warp_oh,
    input  logic [31:0]                  in_instr,
    input  logic [31:0]                  in_pc,
    input  logic                         arm,
    input  logic                         stop,
    input  logic [31:0]                  trig_pc,
`ifdef TRACE_WARP_FILTER_EN
    input  logic [NUM_WARPS-1:0]         warp_mask,
`endif
    input  logic                         rd_ready,
    output logic                         rd_valid,
    output logic [$clog2(NUM_WARPS)-1:0] rd_warp,
    output logic [3:0]                   rd_class,
    output logic [31:0]                  rd_pc,
    output logic [31:0]                  rd_instr,
    output logic [1:0]                   state,
    output logic [$clog2(DEPTH):0]       count,
    output logic [15:0]                  drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(NUM_WARPS);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FROZEN  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     trig_q;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count_q;
    logic [15:0]     drop_q;

    // Entry storage, kept as flops so the head can be shown combinationally.
    logic [WW-1:0]   mem_warp  [DEPTH];
    logic [3:0]      mem_class [DEPTH];
    logic [31:0]     mem_pc    [DEPTH];
    logic [31:0]     mem_instr [DEPTH];

    logic [WW-1:0]   warp_idx;
    logic [3:0]      in_class;
    logic            trig_hit;
    logic            cap_active;
    logic            warp_ok;
    logic            warp_pass;
    logic            full;
    logic            pop;
    logic            take;
    logic            bad_warp;
    logic            want_wr;
    logic            overflow_freeze;
    logic            do_wr;
    logic            overwrite;
    logic            adv;
    logic            drop_inc;

    // Opcode-based instruction classifier. The R-ALU opcode group only
    // counts as R-ALU when funct is one of the supported operations;
    // anything else falls into class 15.
    function automatic logic [3:0] classify(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] cls;
        op  = instr[31:26];
        fn  = instr[5:0];
        cls = 4'd15;
        casez (op)
            6'b0?0000: begin
                case (fn)
                    6'b100000, 6'b100010, 6'b011000, 6'b100100,
                    6'b100101, 6'b100110, 6'b000010, 6'b000000: cls = 4'd1;
                    default:                                    cls = 4'd15;
                endcase
            end
            6'b0?1000, 6'b0?1100, 6'b0?1101, 6'b0?1110: cls = 4'd2;
            6'b1?0011, 6'b1?0111:                       cls = 4'd3;
            6'b1?1011, 6'b1?1111:                       cls = 4'd4;
            6'b0?0100, 6'b0?0111:                       cls = 4'd5;
            6'b0?0010:                                  cls = 4'd6;
            6'b000011:                                  cls = 4'd7;
            6'b000110:                                  cls = 4'd8;
            6'b100001:                                  cls = 4'd9;
            6'b0?0001:                                  cls = 4'd10;
            default:                                    cls = 4'd15;
        endcase
        return cls;
    endfunction

    // One-hot to binary warp index. This is only meaningful when warp_ok is
    // set; multi-hot vectors are rejected before any write.
    always_comb begin
        warp_idx = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (in_warp_oh[i]) begin
                warp_idx = WW'(i);
            end
        end
    end

    assign in_class = classify(in_instr);
    assign warp_ok  = $onehot(in_warp_oh);

`ifdef TRACE_WARP_FILTER_EN
    assign warp_pass = ((in_warp_oh & ~warp_mask) == '0);
`else
    assign warp_pass = 1'b1;
`endif

    // Write/pop qualification.
    // The triggering instruction is itself captured, so capture is active in
    // ARMED on the hit cycle as well as in CAPTURE. arm takes priority over
    // everything: it empties the buffer, so no pop or write takes effect.
    // A pop in the same cycle frees a slot. A write into a full buffer with
    // a simultaneous pop is therefore not an overflow.
    always_comb begin
        trig_hit        = (state_q == ARMED) && in_valid && (in_pc == trig_q);
        cap_active      = (state_q == CAPTURE) || trig_hit;
        full            = (count_q == FULL_CNT);
        pop             = rd_valid && rd_ready && !arm;
        take            = !arm && cap_active && in_valid && warp_pass;
        bad_warp        = take && !warp_ok;
        want_wr         = take && warp_ok;
        overflow_freeze = want_wr && full && !pop && (WRAP == 0);
        do_wr           = want_wr && !overflow_freeze;
        overwrite       = do_wr && full && !pop;
        adv             = pop || overwrite;
        drop_inc        = bad_warp || overwrite || overflow_freeze;
    end

    // Next-state logic. arm restarts the capture from any state. stop and a
    // frozen overflow only matter while capturing. FROZEN is left only
    // through arm or reset.
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ARMED;
        end else begin
            case (state_q)
                ARMED: begin
                    if (trig_hit) begin
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (stop || overflow_freeze) begin
                        state_d = FROZEN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Control state: FSM, trigger latch, pointers, occupancy and drop count.
    // An overwrite writes at wr_ptr (equal to rd_ptr when full) and pushes
    // the head forward, so the count stays at DEPTH. A pop together with a
    // write also leaves the count unchanged. The head advances only once
    // because adv is a single OR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            trig_q  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            if (arm) begin
                trig_q  <= trig_pc;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (do_wr) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (adv) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (do_wr && !adv) begin
                    count_q <= count_q + 1'b1;
                end else if (adv && !do_wr) begin
                    count_q <= count_q - 1'b1;
                end
            end
            if (drop_inc && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 1'b1;
            end
        end
    end

    // Entry storage. The payload needs no reset because the read port masks
    // it while the buffer is empty.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_warp[wr_ptr]  <= warp_idx;
            mem_class[wr_ptr] <= in_class;
            mem_pc[wr_ptr]    <= in_pc;
            mem_instr[wr_ptr] <= in_instr;
        end
    end

    assign rd_valid = (count_q != '0);
    assign rd_warp  = rd_valid ? mem_warp[rd_ptr]  : '0;
    assign rd_class = rd_valid ? mem_class[rd_ptr] : '0;
    assign rd_pc    = rd_valid ? mem_pc[rd_ptr]    : '0;
    assign rd_instr = rd_valid ? mem_instr[rd_ptr] : '0;

    assign state    = state_q;
    assign count    = count_q;
    assign drop_cnt = drop_q;

endmodule
